dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the core's memory stage and a DMA/debug loader port.

---
 rtl/riscv_mem_pkg.sv | 15 +
 rtl/sat_counter.sv | 40 ++++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the data-memory path.
//   owner_e : which requester currently owns the memory port (core or DMA).
//   DEF_AW  : default address width.
//   DEF_DW  : default data width.
package riscv_mem_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk     : clock
//   reset   : asynchronous reset, active-low (count returns to 0)
//   inc_i   : increment by one unless already at LIMIT
//   clr_i   : clear to 0 (takes precedence over inc_i)
//   count_o : current count
module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < LIMIT)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core M stage and a
// DMA/debug loader port. The core has default priority; the DMA gets bounded
// bursts and is guaranteed a grant after a fixed number of denied cycles.
// Grants are combinational, so every granted access completes in the same cycle.
// Optional feature: define DMEM_ARB_STATS_EN to add conflict/stall statistics.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   core_req/we/addr/wdata          : core access request
//   core_rdata, core_stall          : core load data, core denied this cycle
//   dma_req/we/addr/wdata           : DMA request (held stable until dma_ack)
//   dma_ack, dma_rdata              : DMA access performed, DMA read data
//   mem_we/addr/wdata, mem_rdata    : memory side
//   stat_conflicts, stat_core_stalls: (DMEM_ARB_STATS_EN only) saturating counters
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_conflicts,
  output logic [31:0]   stat_core_stalls
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  owner_e        owner_q, owner_d;
  logic [BW-1:0] burst_cnt_q;
  logic [SW-1:0] starve_cnt_q;
  logic          gnt_dma;
  logic          starve_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_CORE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grant is suppressed while reset is low so no access can leak out.
  always_comb begin
    gnt_dma    = 1'b0;
    owner_d    = OWN_CORE;
    dma_ack    = 1'b0;
    core_stall = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    if (reset && dma_req) begin
      case (owner_q)
        OWN_CORE: gnt_dma = !core_req || (starve_cnt_q == STARVE_MAX);
        OWN_DMA:  gnt_dma = !core_req || (burst_cnt_q < BURST_MAX);
        default:  gnt_dma = 1'b0;
      endcase
    end
    if (gnt_dma) begin
      owner_d   = OWN_DMA;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else begin
      mem_we    = core_we & core_req & reset;
    end
    dma_ack    = gnt_dma;
    core_stall = core_req & gnt_dma;
  end

  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

  // Burst length restarts at 1 on entry because it is cleared on every
  // non-DMA cycle.
  sat_counter #(.WIDTH(BW), .LIMIT(BURST_MAX)) u_burst_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (gnt_dma),
    .clr_i   (!gnt_dma),
    .count_o (burst_cnt_q)
  );

  assign starve_inc = dma_req & !gnt_dma;

  sat_counter #(.WIDTH(SW), .LIMIT(STARVE_MAX)) u_starve_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (starve_inc),
    .clr_i   (!starve_inc),
    .count_o (starve_cnt_q)
  );

`ifdef DMEM_ARB_STATS_EN
  sat_counter #(.WIDTH(32), .LIMIT(32'hFFFF_FFFF)) u_stat_conflicts (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (core_req & dma_req),
    .clr_i   (1'b0),
    .count_o (stat_conflicts)
  );

  sat_counter #(.WIDTH(32), .LIMIT(32'hFFFF_FFFF)) u_stat_core_stalls (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (core_stall),
    .clr_i   (1'b0),
    .count_o (stat_core_stalls)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// starvation/burst/reset sequences, then randomized traffic against a
// behavioural grant model and a shadow memory.
module tb_dmem_arbiter;

  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        coreReq, coreWe, coreStall;
  logic [31:0] coreAddr, coreWdata, coreRdata;
  logic        dmaReq, dmaWe, dmaAck;
  logic [31:0] dmaAddr, dmaWdata, dmaRdata;
  logic        memWe;
  logic [31:0] memAddr, memWdata, memRdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] statConflicts, statCoreStalls;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model state: length of the current DMA run, and how many
  // consecutive cycles the DMA has been waiting.
  int mRun = 0;
  int mWait = 0;
  logic [31:0] shadowMem [0:255];
  logic [31:0] memArr [0:255];

  logic        lastExpGnt, lastExpWe;
  logic [31:0] lastExpAddr, lastExpWdata;
  logic        sawAck, sawStall, sawWe;
  logic [31:0] sawAddr, sawCoreRd, sawDmaRd;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(32), .DW(32), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (coreReq),
    .core_we    (coreWe),
    .core_addr  (coreAddr),
    .core_wdata (coreWdata),
    .core_rdata (coreRdata),
    .core_stall (coreStall),
    .dma_req    (dmaReq),
    .dma_we     (dmaWe),
    .dma_addr   (dmaAddr),
    .dma_wdata  (dmaWdata),
    .dma_ack    (dmaAck),
    .dma_rdata  (dmaRdata),
    .mem_we     (memWe),
    .mem_addr   (memAddr),
    .mem_wdata  (memWdata),
    .mem_rdata  (memRdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_conflicts   (statConflicts),
    .stat_core_stalls (statCoreStalls)
`endif
  );

  // Memory: combinational read, write on rising edge.
  assign memRdata = memArr[memAddr[9:2]];
  always @(posedge clk) begin
    if (memWe) memArr[memAddr[9:2]] <= memWdata;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic modelGrant(input logic cr, input logic dr);
    if (!reset || !dr) return 1'b0;
    if (!cr) return 1'b1;
    if (mRun > 0) return (mRun < MAX_BURST);
    return (mWait >= STARVE_LIMIT);
  endfunction

  task automatic checkOutput();
    lastExpGnt   = modelGrant(coreReq, dmaReq);
    lastExpWe    = lastExpGnt ? dmaWe : (coreReq & coreWe & reset);
    lastExpAddr  = lastExpGnt ? dmaAddr : coreAddr;
    lastExpWdata = lastExpGnt ? dmaWdata : coreWdata;
    check("model_dma_ack", {31'b0, sawAck}, {31'b0, lastExpGnt});
    check("model_core_stall", {31'b0, sawStall}, {31'b0, coreReq & lastExpGnt});
    check("model_mem_we", {31'b0, sawWe}, {31'b0, lastExpWe});
    check("model_mem_addr", sawAddr, lastExpAddr);
    if (lastExpWe) check("model_mem_wdata", memWdata, lastExpWdata);
    if (lastExpGnt && !dmaWe) check("model_dma_rdata", sawDmaRd, shadowMem[dmaAddr[9:2]]);
    if (!lastExpGnt && coreReq && !coreWe) check("model_core_rdata", sawCoreRd, shadowMem[coreAddr[9:2]]);
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    coreReq = cr; coreWe = cw; coreAddr = ca; coreWdata = cd;
    dmaReq = dr; dmaWe = dw; dmaAddr = da; dmaWdata = dd;
    #1;
    sawAck = dmaAck; sawStall = coreStall; sawWe = memWe; sawAddr = memAddr;
    sawCoreRd = coreRdata; sawDmaRd = dmaRdata;
    checkOutput();
    @(posedge clk);
    if (lastExpWe) shadowMem[lastExpAddr[9:2]] = lastExpWdata;
    mRun  = lastExpGnt ? mRun + 1 : 0;
    mWait = (!lastExpGnt && dr) ? mWait + 1 : 0;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        expStall, expAck, expWe;
    logic [31:0] expAddr;
    logic        chkRd;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    logic coreGot;
    logic dPend, dW, cR, cW;
    logic [31:0] dA, dD;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] conf0, stall0;
`endif

    for (int i = 0; i < 256; i++) begin
      memArr[i] <= '0;
      shadowMem[i] = '0;
    end

    // Reset state: everything requesting, nothing may reach memory.
    reset = 1'b0;
    coreReq = 1'b1; coreWe = 1'b1; coreAddr = 32'h10; coreWdata = 32'h1234;
    dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 32'h14; dmaWdata = 32'h5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_we", {31'b0, memWe}, 32'd0);
    check("reset_dma_ack", {31'b0, dmaAck}, 32'd0);
    check("reset_core_stall", {31'b0, coreStall}, 32'd0);
    check("reset_no_write", memArr[4], 32'd0);
    coreReq = 1'b0; dmaReq = 1'b0;
    reset = 1'b1;

    vecs[0] = '{1,1,32'h40,32'hDEADBEEF, 0,0,32'h0,32'h0,        0,0,1,32'h40, 0,32'h0};
    vecs[1] = '{1,0,32'h40,32'h0,        0,0,32'h0,32'h0,        0,0,0,32'h40, 1,32'hDEADBEEF};
    vecs[2] = '{0,0,32'h44,32'h0,        1,1,32'h100,32'h11111111, 0,1,1,32'h100, 0,32'h0};
    vecs[3] = '{0,0,32'h44,32'h0,        1,1,32'h104,32'h22222222, 0,1,1,32'h104, 0,32'h0};
    vecs[4] = '{0,0,32'h44,32'h0,        1,1,32'h108,32'h33333333, 0,1,1,32'h108, 0,32'h0};
    vecs[5] = '{0,0,32'h44,32'h0,        0,0,32'h0,32'h0,        0,0,0,32'h44, 0,32'h0};
    vecs[6] = '{0,0,32'h44,32'h0,        1,0,32'h104,32'h0,      0,1,0,32'h104, 1,32'h22222222};
    vecs[7] = '{1,0,32'h108,32'h0,       0,0,32'h0,32'h0,        0,0,0,32'h108, 1,32'h33333333};
    vecs[8] = '{1,0,32'h100,32'h0,       1,1,32'h10C,32'h44444444, 0,0,0,32'h100, 1,32'h11111111};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                    vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
      check($sformatf("vec%0d_stall", i), {31'b0, sawStall}, {31'b0, vecs[i].expStall});
      check($sformatf("vec%0d_ack", i), {31'b0, sawAck}, {31'b0, vecs[i].expAck});
      check($sformatf("vec%0d_we", i), {31'b0, sawWe}, {31'b0, vecs[i].expWe});
      check($sformatf("vec%0d_addr", i), sawAddr, vecs[i].expAddr);
      if (vecs[i].chkRd)
        check($sformatf("vec%0d_rdata", i), vecs[i].expAck ? sawDmaRd : sawCoreRd, vecs[i].expRd);
    end
    check("dma_write_0x100", memArr[8'h40], 32'h11111111);
    check("dma_write_0x108", memArr[8'h42], 32'h33333333);

    // Starvation: core holds the port, DMA waits STARVE_LIMIT cycles.
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      applyStimulus(1, 0, 32'h40, 0, 1, 1, 32'h180, 32'h5A5A0000);
      check($sformatf("starve_wait%0d_ack", i), {31'b0, sawAck}, 32'd0);
      check($sformatf("starve_wait%0d_stall", i), {31'b0, sawStall}, 32'd0);
    end
    applyStimulus(1, 0, 32'h40, 0, 1, 1, 32'h180, 32'h5A5A0000);
    check("starve_forced_ack", {31'b0, sawAck}, 32'd1);
    check("starve_forced_stall", {31'b0, sawStall}, 32'd1);
    applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0);
    check("starve_after_stall", {31'b0, sawStall}, 32'd0);
    check("starve_written", memArr[8'h60], 32'h5A5A0000);

    // Burst cap: 3 DMA beats already in the run, then the core asks.
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 32'h40, 0, 1, 1, 32'h200 + 32'(4 * i), 32'(i));
    acks = 0;
    coreGot = 1'b0;
    for (int i = 0; i < 20 && !coreGot; i++) begin
      applyStimulus(1, 0, 32'h40, 0, 1, 1, 32'h220 + 32'(4 * i), 32'hB000 + 32'(i));
      if (sawAck) acks++;
      else coreGot = 1'b1;
    end
    check("burst_cap_acks", 32'(acks), 32'(MAX_BURST - 3));
    check("burst_cap_core_granted", {31'b0, coreGot}, 32'd1);
    check("burst_cap_no_stall", {31'b0, sawStall}, 32'd0);
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 0);

    // Reset asserted in the middle of a DMA write burst.
    applyStimulus(0, 0, 32'h40, 0, 1, 1, 32'h300, 32'hCAFE0001);
    applyStimulus(0, 0, 32'h40, 0, 1, 1, 32'h304, 32'hCAFE0002);
    @(negedge clk);
    coreReq = 1'b1; coreWe = 1'b1; coreAddr = 32'h3F0; coreWdata = 32'hBADBAD00;
    dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 32'h308; dmaWdata = 32'hBADBAD01;
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_we", {31'b0, memWe}, 32'd0);
    check("midrst_dma_ack", {31'b0, dmaAck}, 32'd0);
    check("midrst_core_stall", {31'b0, coreStall}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_no_dma_write", memArr[8'hC2], 32'd0);
    check("midrst_no_core_write", memArr[8'hFC], 32'd0);
    mRun = 0;
    mWait = 0;
    coreReq = 1'b0; dmaReq = 1'b0;
    reset = 1'b1;
    applyStimulus(1, 0, 32'h304, 0, 1, 0, 32'h300, 0);
    check("postrst_core_owner", {31'b0, sawAck}, 32'd0);
    check("postrst_no_stall", {31'b0, sawStall}, 32'd0);
    check("postrst_readback", sawCoreRd, 32'hCAFE0002);
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 0);

`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    conf0 = statConflicts;
    stall0 = statCoreStalls;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 32'h40, 0, 1, 1, 32'h380, 32'h77);
      if (lastExpGnt) acks++;
    end
    #1;
    check("stat_conflicts", statConflicts - conf0, 32'd10);
    check("stat_core_stalls", statCoreStalls - stall0, 32'(acks));
    applyStimulus(0, 0, 32'h40, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic; DMA operands stay fixed until the access is granted.
    dPend = 1'b0; dW = 1'b0; dA = '0; dD = '0;
    for (int i = 0; i < 400; i++) begin
      if (!dPend) begin
        dPend = ($urandom_range(0, 2) != 0);
        dW = 1'($urandom_range(0, 1));
        dA = 32'($urandom_range(0, 255)) << 2;
        dD = $urandom;
      end
      cR = ($urandom_range(0, 3) != 0);
      cW = 1'($urandom_range(0, 1));
      applyStimulus(cR, cW, 32'($urandom_range(0, 255)) << 2, $urandom, dPend, dW, dA, dD);
      if (lastExpGnt) dPend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
